// File: rtl/sobel_out_streamer_pkg.sv
// Shared constants and types for the Sobel output readback streamer.
// Image geometry, memory widths and the streamer state encoding.
package sobel_out_streamer_pkg;

  localparam int DATA_WIDTH        = 8;
  localparam int ADDR_WIDTH        = 8;
  localparam int IMAGE_ROW_SIZE    = 16;
  localparam int IMAGE_COLUMN_SIZE = 16;
  localparam int PIXEL_COUNT       = IMAGE_ROW_SIZE * IMAGE_COLUMN_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } streamer_state_e;

endpackage

// File: rtl/sobel_skid_fifo.sv
// Two-entry FIFO holding pixel data plus a last-beat tag.
// Ports: clk_i, rst_i (sync, active-high), push_i/push_data_i/push_last_i,
//        pop_i, data_o/last_o (head entry), count_o (occupancy 0..2).
module sobel_skid_fifo #(
  parameter int DATA_WIDTH = sobel_out_streamer_pkg::DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic [1:0]            last_q;
  logic                  wr_q;
  logic                  rd_q;
  logic [1:0]            count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push_i) begin
        data_q[wr_q] <= push_data_i;
        last_q[wr_q] <= push_last_i;
        wr_q         <= ~wr_q;
      end
      if (pop_i) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign data_o  = data_q[rd_q];
  assign last_o  = last_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/sobel_out_streamer.sv
// Reads the output image memory in address order and streams it out.
// Ports: clk_i, rst_i, start_i; mem_addr_o/mem_sel_o/mem_data_i to memory;
//        m_data_o/m_valid_o/m_ready_i/m_last_o stream; busy_o, done_o.
module sobel_out_streamer #(
  parameter int DATA_WIDTH  = sobel_out_streamer_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = sobel_out_streamer_pkg::ADDR_WIDTH,
  parameter int PIXEL_COUNT = sobel_out_streamer_pkg::PIXEL_COUNT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_sel_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  import sobel_out_streamer_pkg::*;

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PIXEL_COUNT - 1);

  streamer_state_e state_q;
  logic [CW-1:0]   addr_q;
  logic [CW-1:0]   beat_q;
  logic            inflight_q;
  logic            done_q;

  logic            pop;
  logic            push;
  logic            issue;
  logic [2:0]      occ;
  logic [1:0]      fifo_count;
  logic            head_last;

  assign pop  = m_valid_o & m_ready_i;
  assign push = inflight_q;

  // Occupancy after this edge: buffered + in flight - leaving.
  // Capping it at 2 keeps the 2-entry FIFO from ever overflowing.
  assign occ   = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign issue = (state_q == ST_READ) && (occ < 3'd2);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        addr_q <= addr_q + 1'b1;
      end
      if (push) begin
        beat_q <= beat_q + 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_READ;
            addr_q  <= '0;
            beat_q  <= '0;
          end
        end
        ST_READ: begin
          if (issue && (addr_q == LAST_IDX)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && head_last) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sobel_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (mem_data_i),
    .push_last_i (beat_q == LAST_IDX),
    .pop_i       (pop),
    .data_o      (m_data_o),
    .last_o      (head_last),
    .count_o     (fifo_count)
  );

  assign m_valid_o  = (fifo_count != 2'd0);
  assign m_last_o   = head_last;
  assign mem_addr_o = addr_q[ADDR_WIDTH-1:0];
  assign busy_o     = (state_q != ST_IDLE);
  assign mem_sel_o  = busy_o;
  assign done_o     = done_q;

endmodule
